// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator:
// FSM states, one-hot result encoding and the cascade-input priority decode.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  // One-hot {big, equal, small}; RES_NONE is driven whenever no result is valid.
  typedef enum logic [2:0] {
    RES_NONE = 3'b000,
    BIG      = 3'b100,
    EQUAL    = 3'b010,
    SMALL    = 3'b001
  } res_t;

  typedef struct packed {
    logic decided;
    res_t res;
  } cascade_t;

  // Upstream big wins over equal, equal wins over small; all-zero behaves as equal-in.
  function automatic cascade_t cascade_decode(input logic fi_big,
                                              input logic fi_equal,
                                              input logic fi_small);
    cascade_t c;
    c.decided = 1'b0;
    c.res     = RES_NONE;
    if (fi_big) begin
      c.decided = 1'b1;
      c.res     = BIG;
    end else if (!fi_equal && fi_small) begin
      c.decided = 1'b1;
      c.res     = SMALL;
    end
    return c;
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational unsigned compare of one DIGIT-wide slice.
module cmp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             gt,
  output logic             lt
);

  assign gt = (x > y);
  assign lt = (x < y);

endmodule

// File: rtl/seq_mag_cmp.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, with
// cascade inputs, signed mode and valid/ready handshakes on both sides.
module seq_mag_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             fi_big,
  input  logic             fi_equal,
  input  logic             fi_small,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             fo_big,
  output logic             fo_equal,
  output logic             fo_small,
  output logic             busy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  res_t             first_res;
  res_t             fo;
  logic             found;
  logic             decided;
  logic             dgt;
  logic             dlt;
  logic             differs;
  logic             last;
  res_t             digit_res;
  logic             fin;
  res_t             fin_res;
  cascade_t         casc;
  logic [WIDTH-1:0] msb_flip;

  cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .x  (sa[WIDTH-1 -: DIGIT]),
    .y  (sb[WIDTH-1 -: DIGIT]),
    .gt (dgt),
    .lt (dlt)
  );

  assign casc      = cascade_decode(fi_big, fi_equal, fi_small);
  assign msb_flip  = {signed_mode, {(WIDTH-1){1'b0}}};
  assign differs   = dgt | dlt;
  assign last      = (cnt == CW'(NDIG - 1));
  assign digit_res = dgt ? BIG : (dlt ? SMALL : EQUAL);

  // A cascade-decided request still spends one SCAN cycle so its latency is one edge.
  always_comb begin
    fin     = 1'b0;
    fin_res = first_res;
    if (decided) begin
      fin = 1'b1;
    end else if ((EARLY_EXIT != 0) && differs) begin
      fin     = 1'b1;
      fin_res = digit_res;
    end else if (last) begin
      fin     = 1'b1;
      fin_res = found ? first_res : digit_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      fo        <= RES_NONE;
      cnt       <= '0;
      found     <= 1'b0;
      decided   <= 1'b0;
      first_res <= RES_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Flipping the MSB maps two's-complement order onto unsigned order.
            sa        <= a ^ msb_flip;
            sb        <= b ^ msb_flip;
            decided   <= casc.decided;
            first_res <= casc.res;
            found     <= 1'b0;
            cnt       <= '0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (fin) begin
            state     <= DONE;
            out_valid <= 1'b1;
            fo        <= fin_res;
            cnt       <= '0;
          end else begin
            if (!found && differs) begin
              found     <= 1'b1;
              first_res <= digit_res;
            end
            sa  <= sa << DIGIT;
            sb  <= sb << DIGIT;
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            fo        <= RES_NONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE) & ~rst;
  assign busy     = (state != IDLE);
  assign fo_big   = fo[2];
  assign fo_equal = fo[1];
  assign fo_small = fo[0];

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Directed bench: one early-exit and one constant-latency comparator driven
// with the same requests, checked against hand-computed results and latencies.
module tb_seq_mag_cmp;

  localparam logic [2:0] R_NONE  = 3'b000;
  localparam logic [2:0] R_BIG   = 3'b100;
  localparam logic [2:0] R_EQUAL = 3'b010;
  localparam logic [2:0] R_SMALL = 3'b001;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_mode;
  logic        fi_big;
  logic        fi_equal;
  logic        fi_small;
  logic        out_ready;

  logic in_ready0, out_valid0, big0, eq0, small0, busy0;
  logic in_ready1, out_valid1, big1, eq1, small1, busy1;
  logic [2:0] fo0;
  logic [2:0] fo1;

  int n_checks = 0;
  int n_fail   = 0;

  assign fo0 = {big0, eq0, small0};
  assign fo1 = {big1, eq1, small1};

  always #5 clk = ~clk;

  seq_mag_cmp #(.WIDTH(32), .DIGIT(4), .EARLY_EXIT(1)) u_ee (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .signed_mode(signed_mode),
    .fi_big(fi_big), .fi_equal(fi_equal), .fi_small(fi_small),
    .out_valid(out_valid0), .out_ready(out_ready),
    .fo_big(big0), .fo_equal(eq0), .fo_small(small0), .busy(busy0)
  );

  seq_mag_cmp #(.WIDTH(32), .DIGIT(4), .EARLY_EXIT(0)) u_cl (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .signed_mode(signed_mode),
    .fi_big(fi_big), .fi_equal(fi_equal), .fi_small(fi_small),
    .out_valid(out_valid1), .out_ready(out_ready),
    .fo_big(big1), .fo_equal(eq1), .fo_small(small1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic sm,
                       input logic [2:0] fi);
    a           = va;
    b           = vb;
    signed_mode = sm;
    {fi_big, fi_equal, fi_small} = fi;
  endtask

  // lat1 == 0 skips the constant-latency instance's latency check.
  task automatic do_req(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic sm, input logic [2:0] fi, input logic [2:0] exp_res,
                        input int lat0, input int lat1);
    int got0 = 0;
    int got1 = 0;
    logic [2:0] r0 = R_NONE;
    logic [2:0] r1 = R_NONE;
    drive(va, vb, sm, fi);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drive(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 3'b000);
    check({tag, "_accept_busy"}, {30'd0, busy0, busy1}, 32'd3);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (got0 == 0 && out_valid0) begin got0 = k; r0 = fo0; end
      if (got1 == 0 && out_valid1) begin got1 = k; r1 = fo1; end
      if (got0 != 0 && got1 != 0) break;
    end
    check({tag, "_res_ee"}, {29'd0, r0}, {29'd0, exp_res});
    check({tag, "_res_cl"}, {29'd0, r1}, {29'd0, exp_res});
    check({tag, "_lat_ee"}, got0, lat0);
    if (lat1 != 0) check({tag, "_lat_cl"}, got1, lat1);
    else check({tag, "_done_cl"}, {31'd0, got1 != 0}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_idle"}, {26'd0, in_ready0, in_ready1, fo0, out_valid1},
          {26'd0, 1'b1, 1'b1, R_NONE, 1'b0});
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(32'd0, 32'd0, 1'b0, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {26'd0, out_valid0, fo0, busy0, in_ready0}, 32'd0);
    check("reset_state_cl", {26'd0, out_valid1, fo1, busy1, in_ready1}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", {30'd0, in_ready0, in_ready1}, 32'd3);

    do_req("msb_unsigned", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b010, R_BIG,   1, 8);
    do_req("msb_signed",   32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b010, R_SMALL, 1, 8);
    do_req("equal",        32'h1234_5678, 32'h1234_5678, 1'b0, 3'b010, R_EQUAL, 8, 8);
    do_req("lsd_big",      32'h1234_5679, 32'h1234_5678, 1'b0, 3'b010, R_BIG,   8, 8);
    do_req("fi_big",       32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 3'b100, R_BIG,   1, 0);
    do_req("fi_small",     32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 3'b001, R_SMALL, 1, 0);
    do_req("fi_none",      32'd5,         32'd3,         1'b0, 3'b000, R_BIG,   8, 8);
    do_req("fi_big_small", 32'd0,         32'd9,         1'b0, 3'b101, R_BIG,   1, 0);
    do_req("fi_eq_small",  32'd5,         32'd3,         1'b0, 3'b011, R_BIG,   8, 8);
    do_req("neg_equal",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 3'b010, R_EQUAL, 8, 8);
    do_req("neg1_vs_neg2", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 3'b010, R_BIG,   8, 8);
    do_req("first_diff",   32'h2000_0000, 32'h1FFF_FFFF, 1'b0, 3'b010, R_BIG,   1, 8);

    // Backpressure on the early-exit instance while new requests are offered.
    out_ready = 1'b0;
    drive(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b010);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("bp_first", {28'd0, out_valid0, fo0}, {28'd0, 1'b1, R_BIG});
    for (int i = 0; i < 5; i++) begin
      drive(32'd1, 32'd2, 1'b0, 3'b001);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("bp_hold", {27'd0, in_ready0, out_valid0, fo0}, {27'd0, 1'b0, 1'b1, R_BIG});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {27'd0, in_ready0, out_valid0, fo0}, {27'd0, 1'b1, 1'b0, R_NONE});
    repeat (4) @(posedge clk);
    #1;
    check("bp_cl_drained", {30'd0, busy1, out_valid1}, 32'd0);

    // Reset while scanning digit 3 of an equal pair.
    drive(32'h1234_5678, 32'h1234_5678, 1'b0, 3'b010);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", {30'd0, busy0, out_valid0}, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_scan_ee", {26'd0, out_valid0, fo0, busy0, in_ready0}, 32'd0);
    check("rst_scan_cl", {26'd0, out_valid1, fo1, busy1, in_ready1}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", {30'd0, in_ready0, in_ready1}, 32'd3);
    begin
      int spurious = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        if (out_valid0 || out_valid1) spurious++;
      end
      check("rst_no_result", spurious, 0);
    end
    do_req("after_rst", 32'h1234_5679, 32'h1234_5678, 1'b0, 3'b010, R_BIG, 8, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
